// File: rtl/sram_pkg.sv
// Shared types and default geometry for the asynchronous SRAM controller.
package sram_pkg;
   localparam int ADDR_W_DEF  = 20;
   localparam int DATA_W_DEF  = 16;
   localparam int RD_WAIT_DEF = 2;
   localparam int WR_WAIT_DEF = 1;
   localparam int CNT_W       = $clog2(16);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      WR      = 2'd2,
      WR_HOLD = 2'd3
   } sram_state_t;
endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response channel between a requester and the SRAM controller.
interface sram_ctrl_if import sram_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W/8-1:0]   req_be;
   logic [DATA_W-1:0]     req_wdata;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_wait_cnt.sv
// Wait-state down-counter: load on access start, decrement while enabled.
// done is high whenever the count has reached zero.
module sram_wait_cnt import sram_pkg::*; #(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);
endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: read rsp at N+RD_WAIT+1, write rsp at N+WR_WAIT+2,
// be==0 rsp at N+1; req_ready is high only in IDLE, so one access is in flight at a time.
module sram_ctrl import sram_pkg::*; #(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RD_WAIT = RD_WAIT_DEF,
   parameter int WR_WAIT = WR_WAIT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   sram_ctrl_if.slave          bus,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic                sram_ce_n,
   output logic                sram_oe_n,
   output logic                sram_we_n,
   output logic [DATA_W/8-1:0] sram_be_n,
   output logic [DATA_W-1:0]   sram_dq_o,
   output logic                sram_dq_oe,
   input  logic [DATA_W-1:0]   sram_dq_i
);
   localparam int BE_W = DATA_W / 8;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

   if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
      $error("sram_ctrl: DATA_W must be a positive multiple of 8");
   end
   if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
      $error("sram_ctrl: RD_WAIT must be in 1..15");
   end
   if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
      $error("sram_ctrl: WR_WAIT must be in 1..15");
   end

   sram_state_t       state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [BE_W-1:0]   be_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] lane_mask;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              accept;
   logic              rd_done;
   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_load_val;
   logic              cnt_en;
   logic              cnt_done;

   sram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .done     (cnt_done)
   );

   assign bus.req_ready = (state == IDLE) && !rst;
   assign accept        = bus.req_valid && bus.req_ready;
   assign rd_done       = (state == RD) && cnt_done;

   for (genvar g = 0; g < BE_W; g++) begin : g_lane
      assign lane_mask[8*g +: 8] = {8{be_q[g]}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_en       = 1'b0;
      sram_ce_n    = 1'b1;
      sram_oe_n    = 1'b1;
      sram_we_n    = 1'b1;
      sram_dq_oe   = 1'b0;
      sram_be_n    = '1;
      case (state)
         IDLE: begin
            // A zero byte-enable request is answered directly from IDLE without a bus cycle.
            if (accept && bus.req_be != '0) begin
               cnt_load = 1'b1;
               if (bus.req_we) begin
                  state_nxt    = WR;
                  cnt_load_val = WR_LOAD;
               end else begin
                  state_nxt    = RD;
                  cnt_load_val = RD_LOAD;
               end
            end
         end
         RD: begin
            sram_ce_n = 1'b0;
            sram_oe_n = 1'b0;
            sram_be_n = ~be_q;
            cnt_en    = 1'b1;
            if (cnt_done) state_nxt = IDLE;
         end
         WR: begin
            sram_ce_n  = 1'b0;
            sram_we_n  = 1'b0;
            sram_dq_oe = 1'b1;
            sram_be_n  = ~be_q;
            cnt_en     = 1'b1;
            if (cnt_done) state_nxt = WR_HOLD;
         end
         WR_HOLD: begin
            sram_ce_n  = 1'b0;
            sram_dq_oe = 1'b1;
            sram_be_n  = ~be_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= bus.req_addr;
            be_q    <= bus.req_be;
            wdata_q <= bus.req_wdata;
         end
         rsp_valid_q <= rd_done || (state == WR_HOLD) || (accept && bus.req_be == '0);
         rsp_rdata_q <= rd_done ? (sram_dq_i & lane_mask) : '0;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign sram_addr     = addr_q;
   assign sram_dq_o     = wdata_q;
endmodule
